// File: rtl/disk_proj_memory_pkg.sv
// Shared constants for the projection page memory.
package disk_proj_memory_pkg;

    localparam int unsigned DPM_PROJ_W     = 54;
    localparam int unsigned DPM_ADDR_W     = 6;
    localparam int unsigned DPM_MAX_COUNT  = 63;
    localparam int unsigned DPM_NPAGE_BITS = 1;

    // True when a page already holds the largest number of entries it may keep.
    function automatic logic page_full(input logic [DPM_ADDR_W-1:0] count);
        return count == DPM_ADDR_W'(DPM_MAX_COUNT);
    endfunction

endpackage

// File: rtl/disk_proj_memory_if.sv
// Write/read bus between projection calculator, page memory and router.
interface disk_proj_memory_if
    import disk_proj_memory_pkg::*;
#(
    parameter int unsigned PROJ_W = DPM_PROJ_W
) ();

    logic [1:0]            start;
    logic [1:0]            done;
    logic [PROJ_W-1:0]     data_in;
    logic                  wr_en;
    logic [DPM_ADDR_W-1:0] read_add;
    logic [PROJ_W-1:0]     data_out;
    logic [DPM_ADDR_W-1:0] number_out;
    logic                  overflow;

    modport master (
        output start, data_in, wr_en, read_add,
        input  done, data_out, number_out, overflow
    );

    modport slave (
        input  start, data_in, wr_en, read_add,
        output done, data_out, number_out, overflow
    );

endinterface

// File: rtl/disk_proj_memory_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module proj_dpram
#(
    parameter int unsigned DATA_W = 54,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; only the output register is reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/disk_proj_memory.sv
// Paged projection memory: upstream fills the write page for the current BX
// while the router reads the previous BX from the read page (wp-1).
module disk_proj_memory
    import disk_proj_memory_pkg::*;
#(
    parameter int unsigned NPAGE_BITS = DPM_NPAGE_BITS,
    parameter int unsigned PROJ_W     = DPM_PROJ_W
) (
    input  logic               clk,
    input  logic               reset,
    disk_proj_memory_if.slave  bus
);

    localparam int unsigned NPAGE = 1 << NPAGE_BITS;

    typedef logic [NPAGE_BITS-1:0] page_t;
    typedef logic [DPM_ADDR_W-1:0] cnt_t;

    page_t       wp_q, wp_d, rp;
    cnt_t        count_q [NPAGE];
    cnt_t        count_d [NPAGE];
    logic        ovf_q   [NPAGE];
    logic        ovf_d   [NPAGE];
    page_t       wr_page;
    cnt_t        wr_addr;
    logic        wr_we;
    cnt_t        number_q;
    logic        overflow_q;
    logic [1:0]  done_q;

    assign rp = wp_q - page_t'(1);

    // Page switch, counters and write address. The page switch is applied
    // first so a write in the start cycle lands at address 0 of the new page.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_page = wp_q;
        wr_addr = '0;
        wr_we   = 1'b0;
        if (bus.start[0]) begin
            wp_d           = wp_q + page_t'(1);
            count_d[wp_d]  = '0;
            ovf_d[wp_d]    = 1'b0;
            wr_page        = wp_d;
        end
        if (bus.wr_en) begin
            if (page_full(count_d[wr_page])) begin
                ovf_d[wr_page] = 1'b1;
            end else begin
                wr_we            = reset;
                wr_addr          = count_d[wr_page];
                count_d[wr_page] = count_d[wr_page] + cnt_t'(1);
            end
        end
    end

    // Page pointer, per-page state and registered read-page status.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q       <= '0;
            for (int unsigned i = 0; i < NPAGE; i++) begin
                count_q[i] <= '0;
                ovf_q[i]   <= 1'b0;
            end
            number_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= '0;
        end else begin
            wp_q       <= wp_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            number_q   <= count_q[rp];
            overflow_q <= ovf_q[rp];
            done_q     <= bus.start;
        end
    end

    proj_dpram #(
        .DATA_W (PROJ_W),
        .ADDR_W (NPAGE_BITS + DPM_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_we),
        .waddr_i ({wr_page, wr_addr}),
        .wdata_i (bus.data_in),
        .raddr_i ({rp, bus.read_add}),
        .rdata_o (bus.data_out)
    );

    assign bus.number_out = number_q;
    assign bus.overflow   = overflow_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_disk_proj_memory.sv
// Self-checking bench for disk_proj_memory with a read-data scoreboard.
module tb_disk_proj_memory;

    logic clk;
    logic reset;

    disk_proj_memory_if #(.PROJ_W(54)) bus ();

    disk_proj_memory #(
        .NPAGE_BITS (1),
        .PROJ_W     (54)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [53:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start[0] pulse; done must echo it right after the edge.
    task automatic pulse_start();
        bus.start = 2'b01;
        do_cycle();
        bus.start = 2'b00;
        check_eq("done_echo", 64'(bus.done), 64'h1);
    endtask

    task automatic write_word(input logic [53:0] v);
        bus.wr_en   = 1'b1;
        bus.data_in = v;
        do_cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop_read(input string tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_underflow"}, 64'h1, 64'h0);
        end else begin
            check_eq(tag, 64'(bus.data_out), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic read_check(input logic [5:0] addr, input logic [53:0] exp);
        bus.read_add = addr;
        exp_q.push_back(exp);
        do_cycle();
        pop_read("data_out");
    endtask

    int unsigned prev_n;
    int unsigned cur_n;

    initial begin
        reset        = 1'b0;
        bus.start    = 2'b00;
        bus.wr_en    = 1'b0;
        bus.data_in  = '0;
        bus.read_add = '0;
        do_cycle();
        do_cycle();
        check_eq("rst_number", 64'(bus.number_out), 64'h0);
        check_eq("rst_overflow", 64'(bus.overflow), 64'h0);
        check_eq("rst_done", 64'(bus.done), 64'h0);
        check_eq("rst_data_out", 64'(bus.data_out), 64'h0);
        reset = 1'b1;

        // Five writes in one BX, then read them back.
        pulse_start();
        for (int i = 1; i <= 5; i++) write_word(54'(i));
        check_eq("done_idle", 64'(bus.done), 64'h0);
        pulse_start();
        do_cycle();
        check_eq("five_number", 64'(bus.number_out), 64'd5);
        check_eq("five_overflow", 64'(bus.overflow), 64'h0);
        for (int i = 0; i < 5; i++) read_check(6'(i), 54'(i + 1));

        // Start and write in the same cycle: word lands at address 0.
        bus.start   = 2'b01;
        bus.wr_en   = 1'b1;
        bus.data_in = 54'hA5;
        do_cycle();
        bus.start   = 2'b00;
        bus.wr_en   = 1'b0;
        pulse_start();
        do_cycle();
        check_eq("same_cycle_number", 64'(bus.number_out), 64'd1);
        read_check(6'd0, 54'hA5);

        // Seventy writes saturate the page at 63 entries.
        pulse_start();
        for (int i = 0; i < 70; i++) write_word(54'h1000 + 54'(i));
        pulse_start();
        do_cycle();
        check_eq("full_number", 64'(bus.number_out), 64'd63);
        check_eq("full_overflow", 64'(bus.overflow), 64'h1);
        read_check(6'd62, 54'h1000 + 54'd62);
        read_check(6'd0, 54'h1000);

        // Following empty BX: overflow cleared with the page.
        pulse_start();
        do_cycle();
        check_eq("empty_number", 64'(bus.number_out), 64'd0);
        check_eq("empty_overflow", 64'(bus.overflow), 64'h0);

        // Alternating 3/7-write BXs while reading the previous BX.
        prev_n = 0;
        for (int k = 0; k < 4; k++) begin
            cur_n = (k % 2 == 0) ? 3 : 7;
            pulse_start();
            do_cycle();
            check_eq("alt_number", 64'(bus.number_out), 64'(prev_n));
            for (int j = 0; j < int'(cur_n); j++) begin
                bus.wr_en    = 1'b1;
                bus.data_in  = 54'((k << 8) | j);
                bus.read_add = 6'(j);
                if (j < int'(prev_n)) exp_q.push_back(54'(((k - 1) << 8) | j));
                do_cycle();
                if (j < int'(prev_n)) pop_read("alt_read");
            end
            bus.wr_en = 1'b0;
            prev_n = cur_n;
        end
        pulse_start();
        do_cycle();
        check_eq("alt_last_number", 64'(bus.number_out), 64'd7);
        for (int j = 0; j < 7; j++) read_check(6'(j), 54'((3 << 8) | j));

        // Reset mid-BX after four writes; start/wr_en held during reset.
        pulse_start();
        for (int i = 0; i < 4; i++) write_word(54'h2000 + 54'(i));
        reset       = 1'b0;
        bus.start   = 2'b11;
        bus.wr_en   = 1'b1;
        bus.data_in = 54'h3FF;
        do_cycle();
        bus.start   = 2'b00;
        bus.wr_en   = 1'b0;
        check_eq("mid_rst_number", 64'(bus.number_out), 64'h0);
        check_eq("mid_rst_overflow", 64'(bus.overflow), 64'h0);
        check_eq("mid_rst_done", 64'(bus.done), 64'h0);
        check_eq("mid_rst_data_out", 64'(bus.data_out), 64'h0);
        reset = 1'b1;
        do_cycle();
        check_eq("post_rst_number", 64'(bus.number_out), 64'h0);
        pulse_start();
        write_word(54'h3001);
        write_word(54'h3002);
        pulse_start();
        do_cycle();
        check_eq("post_rst_count", 64'(bus.number_out), 64'd2);
        read_check(6'd0, 54'h3001);
        read_check(6'd1, 54'h3002);

        // done tracks both start bits with one cycle of delay.
        bus.start = 2'b11;
        do_cycle();
        bus.start = 2'b00;
        check_eq("done_11", 64'(bus.done), 64'h3);
        do_cycle();
        check_eq("done_after_11", 64'(bus.done), 64'h0);
        bus.start = 2'b10;
        do_cycle();
        bus.start = 2'b00;
        check_eq("done_10", 64'(bus.done), 64'h2);

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/disk_proj_memory.md
DISK_PROJ_MEMORY -- requirements
Module: disk_proj_memory

Interface
REQ-001 Parameter NPAGE_BITS, default 1, page-select width (2**NPAGE_BITS BX pages).
REQ-002 Parameter PROJ_W, default 54, projection word width.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  2  start[0] marks the first cycle of a new BX on the write side; start[1] is forwarded only.
REQ-006 done  output  2  start delayed by exactly 1 cycle.
REQ-007 data_in  input  PROJ_W  projection word from the upstream projection calculator.
REQ-008 wr_en  input  1  write strobe for data_in.
REQ-009 read_add  input  6  read address driven by the downstream projection router.
REQ-010 data_out  output  PROJ_W  projection word at read_add, on the read page.
REQ-011 number_out  output  6  entry count of the read page.
REQ-012 overflow  output  1  sticky flag: a write was dropped on the read page.

Function
REQ-013 Storage: 2**NPAGE_BITS pages × 64 entries × PROJ_W bits.
REQ-014 Write page pointer wp and read page pointer rp: rp SHALL equal wp-1, modulo the page count.
REQ-015 On start[0]=1: wp <= wp+1, with wrap-around from the last page to 0; the count and overflow flag of the new wp are cleared in the same cycle.
REQ-016 On wr_en=1: data_in is written at page wp, address count[wp], and count[wp] increments.
REQ-017 start[0] and wr_en both high in the same cycle: the word goes to address 0 of the new page, and the new count is 1.
REQ-018 Full: when count[wp]=63, a write is dropped, the count holds at 63, and overflow[wp] is set.
REQ-019 number_out = count[rp] and overflow = overflow[rp]; both are registered and update 1 cycle after the page switch.
REQ-020 The read page is never written; writes are confined to wp.
REQ-021 data_out is valid exactly 1 cycle after read_add is presented (registered read).
REQ-022 read_add >= number_out returns stale contents; no error is raised; the consumer bounds its reads by number_out.
REQ-023 done[1:0] = start[1:0] registered once.

Reset
REQ-024 On reset=0 at a clock edge: wp <= 0 (so rp = last page); all counts <= 0; all overflow flags <= 0.
REQ-025 On reset=0 at a clock edge: number_out <= 0, overflow <= 0, done <= 0, data_out <= 0.
REQ-026 wr_en and start are ignored during reset.
REQ-027 RAM contents are not cleared by reset.
REQ-028 Reset mid-BX discards that BX's counts; the first start[0] after reset moves wp to page 1.

Structure
REQ-029 The shared package holds PROJ_W, the address width (6), the maximum count (63) and the default NPAGE_BITS.
REQ-030 One sub-module, proj_dpram: simple dual-port RAM with 1 write port and 1 registered read port, address = {page, addr}.
REQ-031 Page pointers, counters and overflow logic reside in disk_proj_memory.

Verification
REQ-032 Reset, then start[0] pulse, then 5 writes (values 1..5), then start[0] pulse -> number_out=5 one cycle later; read_add 0..4 returns 1..5 with 1-cycle latency.
REQ-033 Start and wr_en with value 0xA5 in the same cycle, then start -> number_out=1 and address 0 reads 0xA5.
REQ-034 70 consecutive writes in one BX, then start -> number_out=63, overflow=1; address 62 holds the 63rd word.
REQ-035 NPAGE_BITS=1, alternating BXs with 3 and 7 writes -> number_out alternates 3 and 7; reads during the write BX return only the previous BX's data.
REQ-036 reset=0 asserted mid-BX after 4 writes -> number_out=0, overflow=0, done=0 next cycle; the following start yields counts from new writes only.
REQ-037 start=2'b11 -> done=2'b11 exactly 1 cycle later, and done=0 otherwise.
